xcorr_fft_ctrl: RTL and testbench

- Parametrised framing/config/output-conditioning controller placed between the I/Q sample stream and an AXI-Stream FFT core in the cross-correlation path.
- Sends run-time config (size, direction) at frame boundaries and generates tlast every 2^log2n samples. Input samples are carried under a ready/valid handshake.
- Output side: per-frame length checking, saturating width reduction, sop/eop flags.

---
 rtl/xcorr_fft_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_xcorr_fft_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xcorr_fft_ctrl.sv
// xcorr_fft_ctrl
// Framing, run-time configuration and output conditioning between the I/Q
// sample stream and an AXI-Stream FFT core in the cross-correlation path.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   ival / iready       input sample handshake, data_i/data_q signed IN_W
//   cfg_load/cfg_log2n/ pulse that latches a pending frame size/direction,
//   cfg_fwd             applied at the next frame boundary
//   c_conf_*            core config channel, tdata = {2'b0, fwd, log2n}
//   c_din_*             core input channel, tdata = {Q,I} sign-extended to CORE_W
//   c_dout_*            core output channel (no backpressure), tuser = exponent
//   odata_i/odata_q     saturated, shifted core output, registered
//   oexp/oval/osop/oeop registered exponent, valid, start/end of frame
//   err_len             one-cycle pulse on an output frame length mismatch
//   sat_flag            sticky saturation indicator, cleared only by rst
//
// Assumes CORE_W > IN_W, OUT_W <= CORE_W and CFIFO_DEPTH a power of 2 (>= 2).
module xcorr_fft_ctrl #(
    parameter int IN_W        = 12,
    parameter int CORE_W      = 16,
    parameter int OUT_W       = 12,
    parameter int OUT_LSB     = 0,
    parameter int DEF_LOG2N   = 10,
    parameter int MIN_LOG2N   = 3,
    parameter int MAX_LOG2N   = 12,
    parameter int CFIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ival,
    output logic                  iready,
    input  logic [IN_W-1:0]       data_i,
    input  logic [IN_W-1:0]       data_q,
    input  logic                  cfg_load,
    input  logic [4:0]            cfg_log2n,
    input  logic                  cfg_fwd,
    output logic [7:0]            c_conf_tdata,
    output logic                  c_conf_tvalid,
    input  logic                  c_conf_tready,
    output logic [2*CORE_W-1:0]   c_din_tdata,
    output logic                  c_din_tvalid,
    input  logic                  c_din_tready,
    output logic                  c_din_tlast,
    input  logic [2*CORE_W-1:0]   c_dout_tdata,
    input  logic [7:0]            c_dout_tuser,
    input  logic                  c_dout_tvalid,
    input  logic                  c_dout_tlast,
    output logic [OUT_W-1:0]      odata_i,
    output logic [OUT_W-1:0]      odata_q,
    output logic [7:0]            oexp,
    output logic                  oval,
    output logic                  osop,
    output logic                  oeop,
    output logic                  err_len,
    output logic                  sat_flag
);

    localparam int CNT_W = MAX_LOG2N + 1;
    localparam int AW    = $clog2(CFIFO_DEPTH);
    localparam int OCC_W = AW + 1;
    localparam logic signed [CORE_W-1:0] OMAX = CORE_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [CORE_W-1:0] OMIN = CORE_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {S_CONF, S_STREAM, S_WAITF} state_t;

    function automatic logic [4:0] clamp_log2n(input logic [4:0] v);
        if (v < 5'(MIN_LOG2N)) begin
            return 5'(MIN_LOG2N);
        end else if (v > 5'(MAX_LOG2N)) begin
            return 5'(MAX_LOG2N);
        end
        return v;
    endfunction

    // Returns {saturated, value}.
    function automatic logic [OUT_W:0] sat_conv(input logic [CORE_W-1:0] raw);
        logic signed [CORE_W-1:0] shifted;
        shifted = $signed(raw) >>> OUT_LSB;
        if (shifted > OMAX) begin
            return {1'b1, OMAX[OUT_W-1:0]};
        end else if (shifted < OMIN) begin
            return {1'b1, OMIN[OUT_W-1:0]};
        end
        return {1'b0, shifted[OUT_W-1:0]};
    endfunction

    // ------------------------------------------------------------------
    // Config registers and input-side FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic             run_q;          // low during the first cycle after reset so conf valid starts at 0
    logic [4:0]       act_log2n_q;
    logic             act_fwd_q;
    logic [4:0]       pend_log2n_q;
    logic             pend_fwd_q;
    logic             pend_valid_q;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [CNT_W-1:0] frame_last;
    logic             conf_valid;
    logic             in_stream;
    logic             din_hs;
    logic             frame_end;
    logic             push;
    logic             act_load;

    // FIFO of frame sizes in flight through the core
    logic [4:0]       cfifo_mem [CFIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             fifo_full, fifo_empty;
    logic [4:0]       fifo_head;
    logic             pop_req, pop_ok;

    assign frame_last = (CNT_W'(1) << act_log2n_q) - CNT_W'(1);
    assign fifo_full  = (occ_q == OCC_W'(CFIFO_DEPTH));
    assign fifo_empty = (occ_q == '0);
    assign fifo_head  = cfifo_mem[rd_ptr_q];
    assign pop_ok     = pop_req && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        push       = 1'b0;
        act_load   = 1'b0;
        conf_valid = 1'b0;
        in_stream  = (state_q == S_STREAM);
        din_hs     = in_stream && ival && c_din_tready;
        frame_end  = din_hs && (scnt_q == frame_last);
        case (state_q)
            S_CONF: begin
                conf_valid = run_q;
                if (run_q && c_conf_tready) begin
                    if (!fifo_full) begin
                        push    = 1'b1;
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_WAITF;
                    end
                end
            end
            S_WAITF: begin
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (din_hs) begin
                    if (frame_end) begin
                        scnt_d = '0;
                        if (pend_valid_q) begin
                            act_load = 1'b1;
                            state_d  = S_CONF;
                        end else if (!fifo_full) begin
                            push = 1'b1;
                        end else begin
                            state_d = S_WAITF;
                        end
                    end else begin
                        scnt_d = scnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_CONF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CONF;
            run_q        <= 1'b0;
            act_log2n_q  <= 5'(DEF_LOG2N);
            act_fwd_q    <= 1'b1;
            pend_log2n_q <= '0;
            pend_fwd_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            scnt_q       <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            scnt_q  <= scnt_d;
            if (act_load) begin
                act_log2n_q <= pend_log2n_q;
                act_fwd_q   <= pend_fwd_q;
            end
            // A load in the same cycle as the boundary becomes the next pending config.
            if (cfg_load) begin
                pend_log2n_q <= clamp_log2n(cfg_log2n);
                pend_fwd_q   <= cfg_fwd;
                pend_valid_q <= 1'b1;
            end else if (act_load) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign c_conf_tvalid = conf_valid;
    assign c_conf_tdata  = conf_valid ? {2'b00, act_fwd_q, act_log2n_q} : 8'h00;
    assign iready        = in_stream && c_din_tready;
    assign c_din_tvalid  = in_stream && ival;
    assign c_din_tlast   = in_stream && ival && (scnt_q == frame_last);
    assign c_din_tdata   = in_stream ?
        {{(CORE_W-IN_W){data_q[IN_W-1]}}, data_q, {(CORE_W-IN_W){data_i[IN_W-1]}}, data_i} : '0;

    // ------------------------------------------------------------------
    // Frame-length FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            cfifo_mem[wr_ptr_q] <= act_log2n_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop_ok})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output conditioning and length check
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic [CNT_W-1:0] ocnt_inc;
    logic [CNT_W-1:0] exp_len;
    logic             err_d;
    logic [OUT_W:0]   conv_i, conv_q;
    logic [OUT_W-1:0] odata_i_q, odata_q_q;
    logic [7:0]       oexp_q;
    logic             oval_q, osop_q, oeop_q, err_len_q, sat_flag_q;
    logic             sop_pend_q;

    assign ocnt_inc = ocnt_q + CNT_W'(1);
    assign exp_len  = CNT_W'(1) << fifo_head;
    assign conv_i   = sat_conv(c_dout_tdata[CORE_W-1:0]);
    assign conv_q   = sat_conv(c_dout_tdata[2*CORE_W-1:CORE_W]);

    always_comb begin
        pop_req = 1'b0;
        err_d   = 1'b0;
        ocnt_d  = ocnt_q;
        if (c_dout_tvalid) begin
            if (c_dout_tlast) begin
                pop_req = 1'b1;
                ocnt_d  = '0;
                err_d   = fifo_empty || (ocnt_inc != exp_len);
            end else if (!fifo_empty && (ocnt_inc == exp_len)) begin
                // Expected length reached without tlast: realign on the next beat.
                pop_req = 1'b1;
                ocnt_d  = '0;
                err_d   = 1'b1;
            end else begin
                ocnt_d = ocnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ocnt_q     <= '0;
            odata_i_q  <= '0;
            odata_q_q  <= '0;
            oexp_q     <= '0;
            oval_q     <= 1'b0;
            osop_q     <= 1'b0;
            oeop_q     <= 1'b0;
            err_len_q  <= 1'b0;
            sat_flag_q <= 1'b0;
            sop_pend_q <= 1'b1;
        end else begin
            ocnt_q    <= ocnt_d;
            oval_q    <= c_dout_tvalid;
            err_len_q <= err_d;
            if (c_dout_tvalid) begin
                odata_i_q  <= conv_i[OUT_W-1:0];
                odata_q_q  <= conv_q[OUT_W-1:0];
                oexp_q     <= c_dout_tuser;
                oeop_q     <= c_dout_tlast;
                osop_q     <= sop_pend_q;
                sop_pend_q <= c_dout_tlast;
                if (conv_i[OUT_W] || conv_q[OUT_W]) begin
                    sat_flag_q <= 1'b1;
                end
            end else begin
                osop_q <= 1'b0;
                oeop_q <= 1'b0;
            end
        end
    end

    assign odata_i  = odata_i_q;
    assign odata_q  = odata_q_q;
    assign oexp     = oexp_q;
    assign oval     = oval_q;
    assign osop     = osop_q;
    assign oeop     = oeop_q;
    assign err_len  = err_len_q;
    assign sat_flag = sat_flag_q;

endmodule

// File: tb/tb_xcorr_fft_ctrl.sv
// Self-checking bench for xcorr_fft_ctrl with default parameters.
module tb_xcorr_fft_ctrl;

    localparam int IN_W   = 12;
    localparam int CORE_W = 16;
    localparam int OUT_W  = 12;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ival = 1'b0;
    logic                iready;
    logic [IN_W-1:0]     data_i = '0, data_q = '0;
    logic                cfg_load = 1'b0;
    logic [4:0]          cfg_log2n = '0;
    logic                cfg_fwd = 1'b0;
    logic [7:0]          c_conf_tdata;
    logic                c_conf_tvalid;
    logic                c_conf_tready = 1'b0;
    logic [2*CORE_W-1:0] c_din_tdata;
    logic                c_din_tvalid;
    logic                c_din_tready = 1'b0;
    logic                c_din_tlast;
    logic [2*CORE_W-1:0] c_dout_tdata = '0;
    logic [7:0]          c_dout_tuser = '0;
    logic                c_dout_tvalid = 1'b0;
    logic                c_dout_tlast = 1'b0;
    logic [OUT_W-1:0]    odata_i, odata_q;
    logic [7:0]          oexp;
    logic                oval, osop, oeop, err_len, sat_flag;

    xcorr_fft_ctrl dut (
        .clk(clk), .rst(rst), .ival(ival), .iready(iready),
        .data_i(data_i), .data_q(data_q),
        .cfg_load(cfg_load), .cfg_log2n(cfg_log2n), .cfg_fwd(cfg_fwd),
        .c_conf_tdata(c_conf_tdata), .c_conf_tvalid(c_conf_tvalid), .c_conf_tready(c_conf_tready),
        .c_din_tdata(c_din_tdata), .c_din_tvalid(c_din_tvalid), .c_din_tready(c_din_tready),
        .c_din_tlast(c_din_tlast),
        .c_dout_tdata(c_dout_tdata), .c_dout_tuser(c_dout_tuser), .c_dout_tvalid(c_dout_tvalid),
        .c_dout_tlast(c_dout_tlast),
        .odata_i(odata_i), .odata_q(odata_q), .oexp(oexp), .oval(oval),
        .osop(osop), .oeop(oeop), .err_len(err_len), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: sampled on the falling edge, cleared while in reset.
    int hs_cnt, data_bad, err_pulses, sop_cnt, eop_cnt;
    int conf_words[$];
    int conf_at[$];
    int tlast_at[$];
    logic [IN_W-1:0]     mon_ei, mon_eq;
    logic [2*CORE_W-1:0] mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            hs_cnt = 0; data_bad = 0; err_pulses = 0; sop_cnt = 0; eop_cnt = 0;
            conf_words.delete(); conf_at.delete(); tlast_at.delete();
        end else begin
            if (c_conf_tvalid && c_conf_tready) begin
                conf_words.push_back(int'(c_conf_tdata));
                conf_at.push_back(hs_cnt);
            end
            if (c_din_tvalid && c_din_tready) begin
                mon_ei  = IN_W'(hs_cnt);
                mon_eq  = ~mon_ei;
                mon_exp = {{(CORE_W-IN_W){mon_eq[IN_W-1]}}, mon_eq, {(CORE_W-IN_W){mon_ei[IN_W-1]}}, mon_ei};
                if (c_din_tdata !== mon_exp) data_bad++;
                if (c_din_tlast) tlast_at.push_back(hs_cnt);
                hs_cnt++;
            end
            if (err_len) err_pulses++;
            if (oval && osop) sop_cnt++;
            if (oval && oeop) eop_cnt++;
        end
    end

    task automatic do_reset(input logic conf_rdy);
        rst = 1'b1; ival = 1'b0; cfg_load = 1'b0;
        c_dout_tvalid = 1'b0; c_dout_tlast = 1'b0; c_dout_tdata = '0;
        c_conf_tready = conf_rdy; c_din_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Streams samples (payload = sample index) until hs_cnt reaches target or the budget expires.
    task automatic stream(input int target, input int budget);
        int cyc = 0;
        ival = 1'b1;
        while (hs_cnt < target && cyc < budget) begin
            data_i = IN_W'(hs_cnt);
            data_q = ~IN_W'(hs_cnt);
            @(posedge clk); #1;
            cyc++;
        end
        ival = 1'b0;
    endtask

    task automatic load(input logic [4:0] n, input logic f);
        cfg_log2n = n; cfg_fwd = f; cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic core_frame(input int n, input bit with_last);
        for (int k = 0; k < n; k++) begin
            c_dout_tvalid = 1'b1;
            c_dout_tdata  = {16'(k), 16'(k)};
            c_dout_tlast  = with_last && (k == n - 1);
            @(posedge clk); #1;
        end
        c_dout_tvalid = 1'b0;
        c_dout_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic int qget(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    typedef struct {
        logic [15:0] ci, cq;
        logic [7:0]  tuser;
        logic [11:0] ei, eq;
        logic        esop, esat;
    } vec_t;

    vec_t vecs[7];
    int   bad;

    initial begin
        vecs[0] = '{16'h0000, 16'h0001, 8'h01, 12'h000, 12'h001, 1'b1, 1'b0};
        vecs[1] = '{16'h07FF, 16'hF800, 8'h02, 12'h7FF, 12'h800, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0123, 8'h03, 12'hFFF, 12'h123, 1'b0, 1'b0};
        vecs[3] = '{16'h0800, 16'h0000, 8'h04, 12'h7FF, 12'h000, 1'b0, 1'b1};
        vecs[4] = '{16'h0900, 16'hF700, 8'h05, 12'h7FF, 12'h800, 1'b0, 1'b1};
        vecs[5] = '{16'hF700, 16'h7FFF, 8'h06, 12'h800, 12'h7FF, 1'b0, 1'b1};
        vecs[6] = '{16'hF7FF, 16'h8000, 8'h07, 12'h800, 12'h800, 1'b0, 1'b1};

        // ---- Reset values with active inputs ----
        rst = 1'b1; ival = 1'b1; c_conf_tready = 1'b1; c_din_tready = 1'b1;
        c_dout_tvalid = 1'b1; c_dout_tdata = 32'h0900_0900; c_dout_tlast = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_conf_tvalid", c_conf_tvalid, 0);
        chk("rst_conf_tdata", c_conf_tdata, 0);
        chk("rst_iready_din_tvalid", {iready, c_din_tvalid, c_din_tlast}, 0);
        chk("rst_out_flags", {oval, osop, oeop, err_len, sat_flag}, 0);
        chk("rst_odata", {odata_i, odata_q, oexp}, 0);
        c_dout_tvalid = 1'b0; c_dout_tdata = '0; c_dout_tlast = 1'b0; ival = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("conf_after_rst", {c_conf_tvalid, c_conf_tdata}, 9'h12A);

        // ---- Two default frames ----
        stream(2048, 3000);
        chk("p1_hs", hs_cnt, 2048);
        chk("p1_conf_n", conf_words.size(), 1);
        chk("p1_conf_word", qget(conf_words, 0), 'h2A);
        chk("p1_tlast_n", tlast_at.size(), 2);
        chk("p1_tlast0", qget(tlast_at, 0), 1023);
        chk("p1_tlast1", qget(tlast_at, 1), 2047);
        chk("p1_data_bad", data_bad, 0);
        chk("p1_err", err_pulses, 0);

        // ---- Mid-frame config, last load wins ----
        do_reset(1'b1);
        stream(300, 400);
        load(5'd31, 1'b1);
        stream(500, 300);
        load(5'd4, 1'b0);
        stream(1056, 700);
        chk("p2_hs", hs_cnt, 1056);
        chk("p2_conf_n", conf_words.size(), 2);
        chk("p2_conf_word1", qget(conf_words, 1), 'h04);
        chk("p2_conf_at", qget(conf_at, 1), 1024);
        chk("p2_tlast_n", tlast_at.size(), 3);
        chk("p2_tlast1", qget(tlast_at, 1), 1039);
        chk("p2_tlast2", qget(tlast_at, 2), 1055);

        // ---- Config channel stall, then high clamp ----
        do_reset(1'b0);
        ival = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (iready !== 1'b0 || c_din_tvalid !== 1'b0 || c_conf_tvalid !== 1'b1 || c_conf_tdata !== 8'h2A) bad++;
            @(posedge clk); #1;
        end
        chk("p3_stall_bad_cycles", bad, 0);
        chk("p3_stall_hs", hs_cnt, 0);
        c_conf_tready = 1'b1;
        stream(100, 200);
        load(5'd31, 1'b0);
        stream(1025, 1100);
        chk("p3_hs", hs_cnt, 1025);
        chk("p3_conf_word1", qget(conf_words, 1), 'h0C);
        chk("p3_tlast0", qget(tlast_at, 0), 1023);
        chk("p3_data_bad", data_bad, 0);

        // ---- Short output frame ----
        do_reset(1'b1);
        stream(1024, 1100);
        core_frame(1023, 1);
        chk("p4_err_short", err_pulses, 1);
        core_frame(1024, 1);
        chk("p4_err_good", err_pulses, 1);
        chk("p4_sop_eop", {sop_cnt, eop_cnt}, {32'd2, 32'd2});
        core_frame(1, 1);
        chk("p4_err_pop_empty", err_pulses, 2);

        // ---- FIFO full -> WAITF, resume on eop, realignment ----
        do_reset(1'b1);
        stream(10, 50);
        load(5'd1, 1'b1);
        stream(1060, 1200);
        chk("p5_waitf_hs", hs_cnt, 1048);
        chk("p5_conf_word1", qget(conf_words, 1), 'h23);
        chk("p5_tlast3", qget(tlast_at, 3), 1047);
        ival = 1'b1;
        #1;
        chk("p5_waitf_iready", {iready, c_din_tvalid}, 0);
        ival = 1'b0;
        core_frame(1024, 1);
        chk("p5_err_frame10", err_pulses, 0);
        stream(1056, 100);
        chk("p5_resume_hs", hs_cnt, 1056);
        chk("p5_tlast4", qget(tlast_at, 4), 1055);
        core_frame(8, 0);
        chk("p5_err_realign", err_pulses, 1);
        core_frame(8, 1);
        chk("p5_err_after_realign", err_pulses, 1);
        core_frame(16, 1);
        chk("p5_err_16beats", err_pulses, 2);
        core_frame(7, 1);
        chk("p5_err_7beats", err_pulses, 3);
        core_frame(1, 1);
        chk("p5_err_empty", err_pulses, 4);
        chk("p5_sop_cnt", sop_cnt, 5);
        chk("p5_eop_cnt", eop_cnt, 5);
        chk("p5_data_bad", data_bad, 0);

        // ---- Output conditioning table ----
        do_reset(1'b0);
        for (int v = 0; v < 7; v++) begin
            c_dout_tvalid = 1'b1;
            c_dout_tdata  = {vecs[v].cq, vecs[v].ci};
            c_dout_tuser  = vecs[v].tuser;
            c_dout_tlast  = 1'b0;
            @(posedge clk); #1;
            $display("vec %0d: core I=%h Q=%h -> odata_i=%h odata_q=%h sop=%b sat=%b",
                     v, vecs[v].ci, vecs[v].cq, odata_i, odata_q, osop, sat_flag);
            chk($sformatf("v%0d_oval", v), oval, 1);
            chk($sformatf("v%0d_odata_i", v), odata_i, vecs[v].ei);
            chk($sformatf("v%0d_odata_q", v), odata_q, vecs[v].eq);
            chk($sformatf("v%0d_oexp", v), oexp, vecs[v].tuser);
            chk($sformatf("v%0d_osop", v), osop, vecs[v].esop);
            chk($sformatf("v%0d_sat", v), sat_flag, vecs[v].esat);
            chk($sformatf("v%0d_err", v), err_len, 0);
        end
        c_dout_tvalid = 1'b0;
        @(posedge clk); #1;
        chk("tbl_oval_low", oval, 0);
        chk("tbl_sat_sticky", sat_flag, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
